spi_rx_deser: RTL

//  SPI receive deserializer: the read-back path of the SPI LCD controller and the receive-side

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_rx_deser.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI LCD controller's receive path.
package spi_pkg;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    RECV      = 2'd2
  } rx_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall pulses
// derived from the synchronized level and one extra history flop.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_rx_deser.sv
// SPI receive deserializer: oversamples sck/cs_n/sdi in the clk domain, builds
// MSB-first words and hands them out through a 1-entry valid/ready holding register.
module spi_rx_deser
  import spi_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter bit SAMPLE_RISE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_sck,
  input  logic             spi_cs_n,
  input  logic             spi_sdi,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_ovf,
  input  logic             ovf_clr,
  output logic             frame_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  // Bit order in the synchronizer bus: {sdi, cs_n, sck}; idle levels match.
  localparam logic [2:0] IDLE_LVL = 3'b010;

  logic [2:0] pins, lvl, rise, fall;
  assign pins = {spi_sdi, spi_cs_n, spi_sck};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    spi_sync_edge #(
      .STAGES   (SYNC_STAGES),
      .RESET_VAL(IDLE_LVL[gi])
    ) u_sync (
      .clk    (clk),
      .rst    (rst),
      .pin_i  (pins[gi]),
      .level_o(lvl[gi]),
      .rise_o (rise[gi]),
      .fall_o (fall[gi])
    );
  end

  logic sample_edge, cs_level, cs_rise, cs_fall, sdi_level;
  logic unused_sync;
  assign sample_edge = SAMPLE_RISE ? rise[0] : fall[0];
  assign cs_level    = lvl[1];
  assign cs_rise     = rise[1];
  assign cs_fall     = fall[1];
  assign sdi_level   = lvl[2];
  assign unused_sync = ^{lvl[0], rise[2], fall[2]};

  // The synchronizers come out of reset holding idle levels, not the pins;
  // WAIT_IDLE only trusts cs_n once the chain has been flushed with real samples.
  logic [SYNC_STAGES:0] prime_q;
  logic                 primed;
  assign primed = prime_q[SYNC_STAGES];

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             ovf_q, ovf_d;
  logic             frame_err_q, frame_err_d;
  logic             word_done, ovf_set;
  logic [WIDTH-1:0] word;

  assign word = {shreg_q[WIDTH-2:0], sdi_level};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    word_done   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (primed && cs_level) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d   = RECV;
          bit_cnt_d = '0;
        end
      end
      RECV: begin
        if (sample_edge) begin
          shreg_d = word;
          if (bit_cnt_q == LAST_BIT) begin
            word_done = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        // cs_n rise is judged against the count after any same-cycle sample.
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_d != '0);
          bit_cnt_d   = '0;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ovf_set    = 1'b0;
    if (word_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = word;
        rx_valid_d = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    ovf_d = ovf_set | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prime_q     <= '0;
      state_q     <= WAIT_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      ovf_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      prime_q     <= {prime_q[SYNC_STAGES-1:0], 1'b1};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      ovf_q       <= ovf_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_ovf    = ovf_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == RECV);

endmodule
